// File: rtl/frame_burst_writer.sv
// Frame uploader: parses the tagged pixel queue, packs pixels into bus words and
// writes them to memory as fixed-length bursts at a linearly advancing address.
module frame_burst_writer #(
    parameter int PIXEL_WIDTH  = 16,
    parameter int BUS_WIDTH    = 32,
    parameter int BURST_WORDS  = 8,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int ADDR_WIDTH   = 21
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic                     queue_empty,
    input  logic [PIXEL_WIDTH:0]     queue_data,
    output logic                     rd_en,
    output logic                     write_rq,
    input  logic                     write_ack,
    output logic [ADDR_WIDTH-1:0]    write_addr,
    output logic                     mem_wr_en,
    output logic [BUS_WIDTH-1:0]     write_data,
    output logic [BUS_WIDTH/8-1:0]   write_mask,
    output logic                     upload_done,
    output logic                     frame_error,
    output logic                     busy
);
    localparam int PPW = BUS_WIDTH / PIXEL_WIDTH;
    localparam int BPP = PIXEL_WIDTH / 8;
    localparam int LW  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int BW  = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam int WW  = $clog2(BURST_WORDS + 1);
    localparam int CW  = $clog2(FRAME_WIDTH + 1);
    localparam int RW  = $clog2(FRAME_HEIGHT + 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_FRAME = 3'd1;
    localparam logic [2:0] S_WAIT_ROW   = 3'd2;
    localparam logic [2:0] S_FILL       = 3'd3;
    localparam logic [2:0] S_REQ        = 3'd4;
    localparam logic [2:0] S_WRITE      = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    localparam logic [1:0] P_NONE  = 2'd0;
    localparam logic [1:0] P_ROW   = 2'd1;
    localparam logic [1:0] P_DONE  = 2'd2;
    localparam logic [1:0] P_FRAME = 2'd3;

    logic [2:0]            state;
    logic [1:0]            pend;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] base_lat;
    logic [RW-1:0]         row;
    logic [CW-1:0]         col;
    logic [WW-1:0]         word_idx;
    logic [LW-1:0]         lane_idx;
    logic [BW-1:0]         beat;
    logic [BUS_WIDTH-1:0]  pix_buf [BURST_WORDS];

    logic                   is_cmd, cmd_sf, cmd_sr, cmd_ef, pop;
    logic                   buf_last, buf_empty, last_beat, apply_tgt;
    logic [1:0]             cmd_tgt, tgt;
    logic [WW-1:0]          filled_words;
    logic [PIXEL_WIDTH-1:0] payload;

    assign payload      = queue_data[PIXEL_WIDTH-1:0];
    assign is_cmd       = queue_data[PIXEL_WIDTH];
    assign cmd_sf       = is_cmd && (payload == '0);
    assign cmd_sr       = is_cmd && (payload == PIXEL_WIDTH'(1));
    assign cmd_ef       = is_cmd && (payload == '1);
    assign rd_en        = (state == S_WAIT_FRAME) || (state == S_WAIT_ROW) || (state == S_FILL);
    assign pop          = rd_en && !queue_empty;
    assign buf_last     = (lane_idx == LW'(PPW - 1)) && (word_idx == WW'(BURST_WORDS - 1));
    assign buf_empty    = (word_idx == '0) && (lane_idx == '0);
    assign last_beat    = (beat == BW'(BURST_WORDS - 1));
    assign filled_words = word_idx + WW'(lane_idx != '0);

    assign write_rq    = (state == S_REQ) || (state == S_WRITE);
    assign mem_wr_en   = (state == S_WRITE);
    assign write_addr  = addr;
    assign upload_done = (state == S_DONE);
    assign busy        = (state != S_IDLE);

    always_comb begin
        cmd_tgt = P_NONE;
        if (cmd_sr)      cmd_tgt = P_ROW;
        else if (cmd_ef) cmd_tgt = P_DONE;
        else if (cmd_sf) cmd_tgt = P_FRAME;
    end

    // A mid-row command either redirects immediately (empty buffer) or after the flush burst.
    always_comb begin
        apply_tgt = 1'b0;
        tgt       = P_NONE;
        if ((state == S_FILL) && pop && is_cmd && buf_empty) begin
            tgt       = cmd_tgt;
            apply_tgt = (cmd_tgt != P_NONE);
        end else if ((state == S_WRITE) && last_beat && (pend != P_NONE)) begin
            tgt       = pend;
            apply_tgt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if ((state == S_FILL) && pop && !is_cmd)
            pix_buf[word_idx[BW-1:0]][lane_idx*PIXEL_WIDTH +: PIXEL_WIDTH] <= payload;
    end

    // Unfilled lanes are masked off here, so the buffer never needs clearing.
    always_comb begin
        write_data = '0;
        write_mask = '0;
        if (state == S_WRITE) begin
            for (int unsigned l = 0; l < PPW; l++) begin
                if ((WW'(beat) < word_idx) || ((WW'(beat) == word_idx) && (LW'(l) < lane_idx))) begin
                    write_data[l*PIXEL_WIDTH +: PIXEL_WIDTH] = pix_buf[beat][l*PIXEL_WIDTH +: PIXEL_WIDTH];
                    write_mask[l*BPP +: BPP] = '1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            pend        <= P_NONE;
            addr        <= '0;
            base_lat    <= '0;
            row         <= '0;
            col         <= '0;
            word_idx    <= '0;
            lane_idx    <= '0;
            beat        <= '0;
            frame_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    addr        <= base_addr;
                    base_lat    <= base_addr;
                    frame_error <= 1'b0;
                    row         <= '0;
                    state       <= S_WAIT_FRAME;
                end
                S_WAIT_FRAME: if (pop && cmd_sf) state <= S_WAIT_ROW;
                S_WAIT_ROW: if (pop) begin
                    if (cmd_sr && (row < RW'(FRAME_HEIGHT))) begin
                        col      <= '0;
                        word_idx <= '0;
                        lane_idx <= '0;
                        state    <= S_FILL;
                    end else if (cmd_ef) begin
                        if (row != RW'(FRAME_HEIGHT)) frame_error <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
                S_FILL: if (pop) begin
                    if (!is_cmd) begin
                        col <= col + CW'(1);
                        if (lane_idx == LW'(PPW - 1)) begin
                            lane_idx <= '0;
                            word_idx <= word_idx + WW'(1);
                        end else begin
                            lane_idx <= lane_idx + LW'(1);
                        end
                        if (buf_last || (col + CW'(1) == CW'(FRAME_WIDTH))) state <= S_REQ;
                    end else begin
                        frame_error <= 1'b1;
                        if ((cmd_tgt != P_NONE) && !buf_empty) begin
                            pend  <= cmd_tgt;
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: if (write_ack) begin
                    beat  <= '0;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    beat <= beat + BW'(1);
                    if (last_beat) begin
                        addr     <= addr + ADDR_WIDTH'(filled_words);
                        word_idx <= '0;
                        lane_idx <= '0;
                        if (pend == P_NONE) begin
                            if (col == CW'(FRAME_WIDTH)) begin
                                row   <= row + RW'(1);
                                state <= S_WAIT_ROW;
                            end else begin
                                state <= S_FILL;
                            end
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (apply_tgt) begin
                pend <= P_NONE;
                case (tgt)
                    P_ROW: begin
                        row      <= row + RW'(1);
                        col      <= '0;
                        word_idx <= '0;
                        lane_idx <= '0;
                        state    <= S_FILL;
                    end
                    P_DONE: state <= S_DONE;
                    P_FRAME: begin
                        row   <= '0;
                        addr  <= base_lat;
                        state <= S_WAIT_ROW;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_frame_burst_writer.sv
// Directed bench for frame_burst_writer: two instances (row widths 8 and 6) share one
// pixel queue model and arbiter model; beats are captured and compared against tables.
module tb_frame_burst_writer;
    localparam int PW = 16, BWID = 32, BURST = 4, AW = 21, H = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic start_a = 1'b0, start_b = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic queue_empty = 1'b1;
    logic [PW:0] queue_data = '0;
    logic write_ack = 1'b0;

    logic rd_en_a, write_rq_a, mem_wr_en_a, upload_done_a, frame_error_a, busy_a;
    logic rd_en_b, write_rq_b, mem_wr_en_b, upload_done_b, frame_error_b, busy_b;
    logic [AW-1:0] write_addr_a, write_addr_b;
    logic [BWID-1:0] write_data_a, write_data_b;
    logic [BWID/8-1:0] write_mask_a, write_mask_b;

    frame_burst_writer #(.PIXEL_WIDTH(PW), .BUS_WIDTH(BWID), .BURST_WORDS(BURST),
                         .FRAME_WIDTH(8), .FRAME_HEIGHT(H), .ADDR_WIDTH(AW)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .base_addr(base_addr),
        .queue_empty(queue_empty), .queue_data(queue_data), .rd_en(rd_en_a),
        .write_rq(write_rq_a), .write_ack(write_ack), .write_addr(write_addr_a),
        .mem_wr_en(mem_wr_en_a), .write_data(write_data_a), .write_mask(write_mask_a),
        .upload_done(upload_done_a), .frame_error(frame_error_a), .busy(busy_a));

    frame_burst_writer #(.PIXEL_WIDTH(PW), .BUS_WIDTH(BWID), .BURST_WORDS(BURST),
                         .FRAME_WIDTH(6), .FRAME_HEIGHT(H), .ADDR_WIDTH(AW)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .base_addr(base_addr),
        .queue_empty(queue_empty), .queue_data(queue_data), .rd_en(rd_en_b),
        .write_rq(write_rq_b), .write_ack(write_ack), .write_addr(write_addr_b),
        .mem_wr_en(mem_wr_en_b), .write_data(write_data_b), .write_mask(write_mask_b),
        .upload_done(upload_done_b), .frame_error(frame_error_b), .busy(busy_b));

    logic sel = 1'b0;
    logic s_rd_en, s_write_rq, s_mem_wr_en, s_upload_done, s_frame_error, s_busy;
    logic [AW-1:0] s_write_addr;
    logic [BWID-1:0] s_write_data;
    logic [BWID/8-1:0] s_write_mask;
    assign s_rd_en       = sel ? rd_en_b       : rd_en_a;
    assign s_write_rq    = sel ? write_rq_b    : write_rq_a;
    assign s_mem_wr_en   = sel ? mem_wr_en_b   : mem_wr_en_a;
    assign s_upload_done = sel ? upload_done_b : upload_done_a;
    assign s_frame_error = sel ? frame_error_b : frame_error_a;
    assign s_busy        = sel ? busy_b        : busy_a;
    assign s_write_addr  = sel ? write_addr_b  : write_addr_a;
    assign s_write_data  = sel ? write_data_b  : write_data_a;
    assign s_write_mask  = sel ? write_mask_b  : write_mask_a;

    int checks = 0;
    int errors = 0;

    logic [PW:0] stream[$];
    int qidx = 0;
    int nbeats, done_cnt, pop_in_req, addr_moved, req_cycles, req_cnt, ack_delay;
    logic rq_prev;
    logic [AW-1:0] addr_prev;
    logic [BWID-1:0] cap_d [16];
    logic [3:0] cap_m [16];
    logic [AW-1:0] cap_a [16];
    logic [BWID-1:0] exp_d [8];
    logic [3:0] exp_m [8];
    logic [AW-1:0] exp_a [8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic refresh_queue();
        queue_empty = (qidx >= stream.size());
        queue_data  = queue_empty ? '0 : stream[qidx];
    endtask

    task automatic push_px(input int v);
        stream.push_back({1'b0, PW'(v)});
    endtask

    task automatic push_cmd(input logic [PW-1:0] c);
        stream.push_back({1'b1, c});
    endtask

    task automatic step();
        logic popped;
        @(negedge clk);
        popped = s_rd_en && !queue_empty;
        if (s_rd_en && s_write_rq) pop_in_req++;
        if (s_mem_wr_en && nbeats < 16) begin
            cap_d[nbeats] = s_write_data;
            cap_m[nbeats] = s_write_mask;
            cap_a[nbeats] = s_write_addr;
        end
        if (s_mem_wr_en) nbeats++;
        if (s_upload_done) done_cnt++;
        if (s_write_rq && rq_prev && (s_write_addr != addr_prev)) addr_moved++;
        rq_prev   = s_write_rq;
        addr_prev = s_write_addr;
        if (s_write_rq && !s_mem_wr_en) begin
            write_ack = (req_cnt >= ack_delay);
            req_cycles++;
            req_cnt++;
        end else begin
            write_ack = 1'b0;
            req_cnt   = 0;
        end
        @(posedge clk);
        #1;
        if (popped) qidx++;
        refresh_queue();
    endtask

    task automatic run_frame(input logic which, input logic [AW-1:0] base, input int delay,
                             input int stop_beats);
        sel = which;
        nbeats = 0; done_cnt = 0; pop_in_req = 0; addr_moved = 0;
        req_cycles = 0; req_cnt = 0; rq_prev = 1'b0; addr_prev = '0;
        ack_delay = delay;
        qidx = 0;
        refresh_queue();
        base_addr = base;
        if (which) start_b = 1'b1; else start_a = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (done_cnt != 0) break;
            if (stop_beats > 0 && nbeats >= stop_beats) break;
            step();
        end
    endtask

    task automatic check_beats(input string tag, input int n);
        check({tag, "_beats"}, 64'(nbeats), 64'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), 64'(cap_d[i]), 64'(exp_d[i]));
            check($sformatf("%s_mask%0d", tag, i), 64'(cap_m[i]), 64'(exp_m[i]));
            check($sformatf("%s_addr%0d", tag, i), 64'(cap_a[i]), 64'(exp_a[i]));
        end
    endtask

    task automatic load_t1();
        stream.delete();
        push_px(16'h55);
        push_cmd('0);
        push_cmd(16'h0001);
        for (int i = 0; i < 8; i++) push_px(i);
        push_cmd(16'h0001);
        for (int i = 8; i < 16; i++) push_px(i);
        push_cmd('1);
    endtask

    task automatic expect_t1();
        exp_d = '{32'h00010000, 32'h00030002, 32'h00050004, 32'h00070006,
                  32'h00090008, 32'h000B000A, 32'h000D000C, 32'h000F000E};
        exp_m = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        exp_a = '{21'h100, 21'h100, 21'h100, 21'h100, 21'h104, 21'h104, 21'h104, 21'h104};
    endtask

    task automatic load_t3();
        stream.delete();
        push_cmd('0);
        push_cmd(16'h0001);
        push_px(16'hA0); push_px(16'hA1); push_px(16'hA2);
        push_cmd(16'h0001);
        for (int i = 16'h10; i < 16'h18; i++) push_px(i);
        push_cmd('1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_write_rq", write_rq_a, 1'b0);
        check("rst_rd_en", rd_en_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_addr", write_addr_a, '0);
        check("rst_err", frame_error_a, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // T1: two full bursts, leading junk before start-frame discarded silently
        load_t1();
        run_frame(1'b0, 21'h100, 0, 0);
        expect_t1();
        check_beats("t1", 8);
        check("t1_done", 64'(done_cnt), 64'd1);
        check("t1_err", frame_error_a, 1'b0);
        check("t1_busy_after", busy_a, 1'b0);

        // T2: 6-pixel rows, one partially filled burst per row
        stream.delete();
        push_cmd('0);
        push_cmd(16'h0001);
        for (int i = 0; i < 6; i++) push_px(i);
        push_cmd(16'h0001);
        for (int i = 6; i < 12; i++) push_px(i);
        push_cmd('1);
        run_frame(1'b1, 21'h100, 3, 0);
        exp_d = '{32'h00010000, 32'h00030002, 32'h00050004, 32'h0,
                  32'h00070006, 32'h00090008, 32'h000B000A, 32'h0};
        exp_m = '{4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0};
        exp_a = '{21'h100, 21'h100, 21'h100, 21'h100, 21'h103, 21'h103, 21'h103, 21'h103};
        check_beats("t2", 8);
        check("t2_done", 64'(done_cnt), 64'd1);
        check("t2_err", frame_error_b, 1'b0);

        // T3: short row flushed with zero padding, next row continues at +2
        load_t3();
        run_frame(1'b0, 21'h100, 0, 0);
        exp_d = '{32'h00A100A0, 32'h000000A2, 32'h0, 32'h0,
                  32'h00110010, 32'h00130012, 32'h00150014, 32'h00170016};
        exp_m = '{4'hF, 4'h3, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF};
        exp_a = '{21'h100, 21'h100, 21'h100, 21'h100, 21'h102, 21'h102, 21'h102, 21'h102};
        check_beats("t3", 8);
        check("t3_done", 64'(done_cnt), 64'd1);
        check("t3_err", frame_error_a, 1'b1);

        // T4: end-frame after one row, with grant delayed 20 cycles
        stream.delete();
        push_cmd('0);
        push_cmd(16'h0001);
        for (int i = 16'h20; i < 16'h28; i++) push_px(i);
        push_cmd('1);
        run_frame(1'b0, 21'h1F0, 20, 0);
        exp_d = '{32'h00210020, 32'h00230022, 32'h00250024, 32'h00270026, 32'h0, 32'h0, 32'h0, 32'h0};
        exp_m = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        exp_a = '{21'h1F0, 21'h1F0, 21'h1F0, 21'h1F0, 21'h0, 21'h0, 21'h0, 21'h0};
        check_beats("t4", 4);
        check("t4_done", 64'(done_cnt), 64'd1);
        check("t4_err", frame_error_a, 1'b1);
        check("t4_req_cycles", 64'(req_cycles), 64'd21);
        check("t4_pop_in_req", 64'(pop_in_req), 64'd0);
        check("t4_addr_moved", 64'(addr_moved), 64'd0);

        // T5: asynchronous reset in the middle of the flush burst
        load_t3();
        run_frame(1'b0, 21'h100, 0, 2);
        check("t5_rq_before", write_rq_a, 1'b1);
        check("t5_err_before", frame_error_a, 1'b1);
        check("t5_addr_before", write_addr_a, 21'h100);
        reset_n = 1'b0;
        #1;
        check("t5_rq", write_rq_a, 1'b0);
        check("t5_wr_en", mem_wr_en_a, 1'b0);
        check("t5_data", write_data_a, '0);
        check("t5_mask", write_mask_a, '0);
        check("t5_addr", write_addr_a, '0);
        check("t5_busy", busy_a, 1'b0);
        check("t5_rd_en", rd_en_a, 1'b0);
        check("t5_err", frame_error_a, 1'b0);
        check("t5_done", upload_done_a, 1'b0);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        load_t1();
        run_frame(1'b0, 21'h100, 1, 0);
        expect_t1();
        check_beats("t5_after", 8);
        check("t5_after_done", 64'(done_cnt), 64'd1);
        check("t5_after_err", frame_error_a, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_burst_writer.md
# frame_burst_writer

Parametrised frame uploader between the camera pixel queue and the PSRAM/SDRAM write arbiter. It parses the tagged pixel stream (start-frame, start-row, end-frame commands), packs pixels into bus words, and buffers them into fixed-length bursts. Each burst is issued to memory at a linearly advancing word address from a per-frame base address. It supports configurable pixel, bus and burst widths, zero-padded partial bursts with byte masks, and frame-integrity checking with a sticky error flag.

## Interface
- PIXEL_WIDTH, 16, bits per pixel; multiple of 8
- BUS_WIDTH, 32, memory data width; multiple of PIXEL_WIDTH; PPW = BUS_WIDTH/PIXEL_WIDTH
- BURST_WORDS, 8, bus words per memory burst (≥1)
- FRAME_WIDTH, 640, pixels per row; multiple of PPW
- FRAME_HEIGHT, 480, rows per frame
- ADDR_WIDTH, 21, word-address width
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  arm for one frame; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  frame base word address; latched on accepted start
- queue_empty  in  1  pixel queue empty
- queue_data  in  PIXEL_WIDTH+1  FWFT head; MSB=1 marks command: {1,0..0}=start frame, {1,0..01}=start row, {1,1..1}=end frame
- rd_en  out  1  pop; entry consumed when rd_en & !queue_empty
- write_rq  out  1  memory request, held until burst end
- write_ack  in  1  grant from arbiter
- write_addr  out  ADDR_WIDTH  burst start word address, stable while write_rq
- mem_wr_en  out  1  data-beat valid
- write_data  out  BUS_WIDTH  beat data, pixel 0 in LSBs
- write_mask  out  BUS_WIDTH/8  byte enables, 1=write
- upload_done  out  1  one-cycle pulse at frame end
- frame_error  out  1  sticky; cleared on accepted start
- busy  out  1  high outside IDLE

## Operation
- States: IDLE, WAIT_FRAME, WAIT_ROW, FILL, REQ, WRITE, DONE.
- IDLE: on start, latch base into addr counter, clear frame_error, row=0 -> WAIT_FRAME.
- WAIT_FRAME: pop everything; start-frame -> WAIT_ROW; all else discarded silently.
- WAIT_ROW: pop; start-row with row<FRAME_HEIGHT -> FILL (col=0, buffer cleared); end-frame -> DONE (frame_error if row≠FRAME_HEIGHT); pixel, extra start-row or start-frame -> discard, set frame_error.
- FILL: pop pixels into word slot col/PPW mod BURST_WORDS, lane col mod PPW; col++. Leave to REQ when buffer full (BURST_WORDS*PPW pixels) or col reaches FRAME_WIDTH.
- FILL commands (popped): start-row -> short row, set frame_error, flush partial buffer, then resume FILL for new row (row++); end-frame -> set frame_error, flush, then DONE; start-frame -> set frame_error, flush, then WAIT_ROW with row=0, addr reset to latched base.
- rd_en = 1 in WAIT_FRAME, WAIT_ROW, FILL; 0 elsewhere (combinational from state).
- REQ: write_rq=1; wait write_ack -> WRITE.
- WRITE: BURST_WORDS beats, mem_wr_en=1 each; filled words mask all-ones; partially filled word masks only valid pixel bytes, data zero-padded; empty words mask 0, data 0. After last beat write_rq=0, addr += filled word count (ceil). Next: FILL if row incomplete, else row++ -> WAIT_ROW; or pending flush target.
- Address arithmetic modulo 2^ADDR_WIDTH (wraps silently).
- DONE: upload_done=1 one cycle -> IDLE.

## Timing
- Reset: all outputs 0, state IDLE, counters 0; reset mid-burst drops write_rq and mem_wr_en immediately (async).
- Pixel visible and popped in same cycle; 1 pixel/cycle max in FILL.
- FILL->REQ one cycle after last pixel popped; write_rq asserts in REQ's first cycle.
- write_ack sampled when write_rq=1; first beat the cycle after ack; beats on consecutive cycles; write_rq deasserts the cycle after the last beat.
- start ignored while busy; write_ack ignored outside REQ.
- Min frame gap: DONE->IDLE->accepting start = 2 cycles.

## Test plan
- PIXEL 16, BUS 32, BURST 4, W 8, H 2, base 0x100; frame of pixels 0..15 -> bursts at 0x100 {0x00010000,0x00030002,…} and 0x104, masks 4'hF, upload_done once, frame_error 0.
- Same params, W 6 -> per row one burst, beats 3 masks 4'hF, beat 4 mask 0; addresses 0x100, 0x103.
- Row 0 has 3 pixels then start-row -> burst words {p1p0},{0000p2} masks F,3,0,0; addr +2; frame_error 1; row 1 normal at 0x102.
- End-frame after 1 row -> upload_done, frame_error 1.
- write_ack delayed 20 cycles -> write_rq, write_addr held; no pops during REQ/WRITE.
- Reset asserted during beat 2 -> all outputs 0 next edge; new start works cleanly.
